alu_4b_stateful_array: RTL and testbench

- Downstream consumer of the per-stage crossbar; the ALU bank for the eight 4-byte PHV containers.
- Takes the crossbar's per-lane operand pairs, the original container values and the delayed action word.
- Performs stateless arithmetic and stateful load, store and load-add against a small per-stage register memory.
- Emits the updated 4B container vector to the PHV re-assembly logic.

---
 rtl/alu_4b_stateful_array_if.sv | 28 ++
 rtl/alu_4b_stateful_array.sv | 176 +++++++++++++++++
 tb/tb_alu_4b_stateful_array.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_4b_stateful_array_if.sv
// Handshake/data bundle between the crossbar, the 4B ALU bank and PHV re-assembly.
// master drives operands/actions, slave (the ALU bank) returns result containers.
interface alu_4b_stateful_array_if #(
    parameter int ACT_LEN  = 25,
    parameter int width_4B = 32
);
    logic                      alu_in_valid;
    logic [width_4B*8-1:0]     alu_in_4B_1;
    logic [width_4B*8-1:0]     alu_in_4B_2;
    logic [width_4B*8-1:0]     alu_in_4B_3;
    logic [ACT_LEN*25-1:0]     action_in;
    logic                      action_in_valid;
    logic [width_4B*8-1:0]     phv_4B_out;
    logic                      phv_4B_out_valid;
    logic                      stateful_conflict;

    modport master (
        output alu_in_valid, alu_in_4B_1, alu_in_4B_2, alu_in_4B_3,
        output action_in, action_in_valid,
        input  phv_4B_out, phv_4B_out_valid, stateful_conflict
    );

    modport slave (
        input  alu_in_valid, alu_in_4B_1, alu_in_4B_2, alu_in_4B_3,
        input  action_in, action_in_valid,
        output phv_4B_out, phv_4B_out_valid, stateful_conflict
    );
endinterface

// File: rtl/alu_4b_stateful_array.sv
// 8-lane 4B container ALU bank with a single-port per-stage stateful memory.
// Macro ALU4B_SATURATE_EN: add/sub clamp instead of wrapping (loadd always wraps).
module alu_4b_stateful_array #(
    parameter int STAGE_ID = 0,
    parameter int ACT_LEN  = 25,
    parameter int width_4B = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    alu_4b_stateful_array_if.slave  io
);
    localparam int NL    = 8;
    localparam int W     = width_4B;
    localparam int DEPTH = 2**ADDR_W;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_ADDI  = 4'b1001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SUBI  = 4'b1010;
    localparam logic [3:0] OP_SET   = 4'b1110;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_LOADD = 4'b1011;
    localparam logic [3:0] OP_STORE = 4'b0111;

    function automatic logic [W-1:0] f_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
`ifdef ALU4B_SATURATE_EN
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        return s[W] ? {W{1'b1}} : s[W-1:0];
`else
        return x + y;
`endif
    endfunction

    function automatic logic [W-1:0] f_sub(input logic [W-1:0] x,
                                           input logic [W-1:0] y);
`ifdef ALU4B_SATURATE_EN
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        return d[W] ? {W{1'b0}} : d[W-1:0];
`else
        return x - y;
`endif
    endfunction

    logic [NL-1:0][3:0]   w_op;
    logic [NL-1:0]        w_stf;
    logic                 w_gnt_vld;
    logic [2:0]           w_gnt_idx;
    logic                 w_conf;

    logic                 r_s1_valid;
    logic [NL-1:0][W-1:0] r_s1_a;
    logic [NL-1:0][W-1:0] r_s1_b;
    logic [NL-1:0][W-1:0] r_s1_c;
    logic [NL-1:0][3:0]   r_s1_op;
    logic                 r_s1_gvld;
    logic [2:0]           r_s1_gidx;
    logic                 r_s1_conf;

    logic [W-1:0]         r_mem [DEPTH];
    logic [ADDR_W-1:0]    w_addr;
    logic [W-1:0]         w_rd;
    logic [3:0]           w_gop;
    logic [NL-1:0][W-1:0] w_res;

    logic [NL*W-1:0]      r_phv;
    logic                 r_phv_valid;
    logic                 r_conflict;

    // Decode lane opcodes; a missing action word forces every lane to no-op.
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            w_op[i]  = io.action_in_valid ?
                       io.action_in[(10+i)*ACT_LEN-1 -: 4] : 4'b0000;
            w_stf[i] = (w_op[i] == OP_LOAD) || (w_op[i] == OP_LOADD) ||
                       (w_op[i] == OP_STORE);
        end
    end

    // Lowest-indexed stateful lane wins the single memory port.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = 3'd0;
        w_conf    = 1'b0;
        for (int i = 0; i < NL; i++) begin
            if (w_stf[i]) begin
                if (w_gnt_vld) begin
                    w_conf = 1'b1;
                end else begin
                    w_gnt_vld = 1'b1;
                    w_gnt_idx = 3'(i);
                end
            end
        end
    end

    // S1: capture operands, opcodes and the grant; data holds on idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_c     <= '0;
            r_s1_op    <= '0;
            r_s1_gvld  <= 1'b0;
            r_s1_gidx  <= 3'd0;
            r_s1_conf  <= 1'b0;
        end else begin
            r_s1_valid <= io.alu_in_valid;
            if (io.alu_in_valid) begin
                r_s1_a    <= io.alu_in_4B_1;
                r_s1_b    <= io.alu_in_4B_2;
                r_s1_c    <= io.alu_in_4B_3;
                r_s1_op   <= w_op;
                r_s1_gvld <= w_gnt_vld;
                r_s1_gidx <= w_gnt_idx;
                r_s1_conf <= w_conf;
            end
        end
    end

    assign w_addr = r_s1_b[r_s1_gidx][ADDR_W-1:0];
    assign w_rd   = r_mem[w_addr];
    assign w_gop  = r_s1_op[r_s1_gidx];

    // S2 per-lane result; stateful results only for the granted lane.
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            w_res[i] = r_s1_c[i];
            case (r_s1_op[i])
                OP_ADD, OP_ADDI: w_res[i] = f_add(r_s1_a[i], r_s1_b[i]);
                OP_SUB, OP_SUBI: w_res[i] = f_sub(r_s1_a[i], r_s1_b[i]);
                OP_SET:          w_res[i] = r_s1_b[i];
                OP_LOAD, OP_LOADD: begin
                    if (r_s1_gvld && (r_s1_gidx == 3'(i)))
                        w_res[i] = w_rd;
                end
                default: ;
            endcase
        end
    end

    // S2 memory write: store writes A, loadd writes old+1 (wrapping).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++)
                r_mem[k] <= '0;
        end else if (r_s1_valid && r_s1_gvld) begin
            if (w_gop == OP_STORE)
                r_mem[w_addr] <= r_s1_a[r_s1_gidx];
            else if (w_gop == OP_LOADD)
                r_mem[w_addr] <= w_rd + 1'b1;
        end
    end

    // S2 output registers; results hold when no PHV is in S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phv       <= '0;
            r_phv_valid <= 1'b0;
            r_conflict  <= 1'b0;
        end else begin
            r_phv_valid <= r_s1_valid;
            r_conflict  <= r_s1_valid & r_s1_conf;
            if (r_s1_valid)
                r_phv <= w_res;
        end
    end

    assign io.phv_4B_out        = r_phv;
    assign io.phv_4B_out_valid  = r_phv_valid;
    assign io.stateful_conflict = r_conflict;
endmodule

// File: tb/tb_alu_4b_stateful_array.sv
// Directed-vector bench for the 4B ALU bank.
// Expected values are hand-computed per test vector.
module tb_alu_4b_stateful_array;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_4b_stateful_array_if bus ();

    alu_4b_stateful_array dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [31:0] a  [8];
    logic [31:0] b  [8];
    logic [31:0] c  [8];
    logic [3:0]  op [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return bus.phv_4B_out[i*32 +: 32];
    endfunction

    task automatic clr();
        for (int i = 0; i < 8; i++) begin
            a[i]  = 32'h0;
            b[i]  = 32'h0;
            c[i]  = 32'hC000_0000 | 32'(i);
            op[i] = 4'h0;
        end
    endtask

    task automatic drive(input logic av);
        logic [624:0] act;
        @(negedge clk);
        act = '0;
        for (int i = 0; i < 8; i++) begin
            bus.alu_in_4B_1[i*32 +: 32] = a[i];
            bus.alu_in_4B_2[i*32 +: 32] = b[i];
            bus.alu_in_4B_3[i*32 +: 32] = c[i];
            act[(9+i)*25+21 +: 4]       = op[i];
        end
        bus.action_in       = act;
        bus.action_in_valid = av;
        bus.alu_in_valid    = 1'b1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.alu_in_valid    = 1'b0;
        bus.action_in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        bus.alu_in_valid    = 1'b0;
        bus.alu_in_4B_1     = '0;
        bus.alu_in_4B_2     = '0;
        bus.alu_in_4B_3     = '0;
        bus.action_in       = '0;
        bus.action_in_valid = 1'b0;
        clr();

        repeat (2) @(negedge clk);
        chk("rst_lane0", lane(0), 32'h0);
        chk("rst_lane7", lane(7), 32'h0);
        chk("rst_valid", 32'(bus.phv_4B_out_valid), 32'h0);
        chk("rst_conf", 32'(bus.stateful_conflict), 32'h0);
        rst_n = 1'b1;

        clr();
        op[0] = 4'b1001; a[0] = 32'h10;       b[0] = 32'h5;
        op[3] = 4'b0010; a[3] = 32'h5;        b[3] = 32'h7;
        op[4] = 4'b0001; a[4] = 32'hFFFFFFFF; b[4] = 32'h2;
        op[5] = 4'b1110; a[5] = 32'h1234;     b[5] = 32'hABCD0001;
        drive(1'b1);
        idle();
        idle();
        chk("addi_l0", lane(0), 32'h15);
        chk("orig_l1", lane(1), 32'hC0000001);
`ifdef ALU4B_SATURATE_EN
        chk("sub_l3", lane(3), 32'h0);
        chk("add_l4", lane(4), 32'hFFFFFFFF);
`else
        chk("sub_l3", lane(3), 32'hFFFFFFFE);
        chk("add_l4", lane(4), 32'h1);
`endif
        chk("set_l5", lane(5), 32'hABCD0001);
        chk("orig_l7", lane(7), 32'hC0000007);
        chk("vld_t2", 32'(bus.phv_4B_out_valid), 32'h1);
        chk("conf_t2", 32'(bus.stateful_conflict), 32'h0);
        idle();
        chk("vld_drop", 32'(bus.phv_4B_out_valid), 32'h0);

        clr();
        op[2] = 4'b0111; a[2] = 32'hDEADBEEF; b[2] = 32'h4;
        drive(1'b1);
        clr();
        op[5] = 4'b1000; b[5] = 32'h4;
        drive(1'b1);
        idle();
        chk("store_l2", lane(2), 32'hC0000002);
        chk("store_l5", lane(5), 32'hC0000005);
        idle();
        chk("load_l5", lane(5), 32'hDEADBEEF);
        chk("load_vld", 32'(bus.phv_4B_out_valid), 32'h1);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        clr();
        op[1] = 4'b1011; b[1] = 32'h7;
        drive(1'b1);
        drive(1'b1);
        drive(1'b1);
        chk("loadd0", lane(1), 32'h0);
        idle();
        chk("loadd1", lane(1), 32'h1);
        idle();
        chk("loadd2", lane(1), 32'h2);
        clr();
        op[1] = 4'b1000; b[1] = 32'h7;
        drive(1'b1);
        idle();
        idle();
        chk("mem7_3", lane(1), 32'h3);

        clr();
        op[2] = 4'b1011; b[2] = 32'h0;
        op[6] = 4'b1011; b[6] = 32'h0;
        drive(1'b1);
        idle();
        idle();
        chk("conf_l2", lane(2), 32'h0);
        chk("conf_l6", lane(6), 32'hC0000006);
        chk("conf_hi", 32'(bus.stateful_conflict), 32'h1);
        idle();
        chk("conf_pulse", 32'(bus.stateful_conflict), 32'h0);
        clr();
        op[0] = 4'b1000; b[0] = 32'h0;
        drive(1'b1);
        idle();
        idle();
        chk("mem0_1", lane(0), 32'h1);
        chk("noconf", 32'(bus.stateful_conflict), 32'h0);

        clr();
        op[0] = 4'b1001; a[0] = 32'h1; b[0] = 32'h1;
        drive(1'b0);
        idle();
        idle();
        chk("noact_l0", lane(0), 32'hC0000000);
        chk("noact_vld", 32'(bus.phv_4B_out_valid), 32'h1);

        clr();
        op[0] = 4'b0111; a[0] = 32'h55; b[0] = 32'h7;
        drive(1'b1);
        @(negedge clk);
        bus.alu_in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_vld0", 32'(bus.phv_4B_out_valid), 32'h0);
        chk("mid_out", lane(0), 32'h0);
        @(negedge clk);
        chk("mid_vld1", 32'(bus.phv_4B_out_valid), 32'h0);
        clr();
        op[3] = 4'b1000; b[3] = 32'h7;
        drive(1'b1);
        idle();
        idle();
        chk("mid_mem7", lane(3), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
